// File: rtl/ctrl_pkg.sv
// Shared definitions for the multi-cycle controller: state encodings,
// opcode values, datapath mux/ALU select codes and the opcode class vector.
// The TRAP state only exists when ILLEGAL_TRAP_EN is defined.
package ctrl_pkg;

  localparam int STATE_BITS = 4;

  typedef enum logic [STATE_BITS-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
`ifdef ILLEGAL_TRAP_EN
    , S_TRAP   = 4'd11
`endif
  } state_e;

  localparam logic [6:0] OP_LW  = 7'd3;
  localparam logic [6:0] OP_SW  = 7'd35;
  localparam logic [6:0] OP_R   = 7'd51;
  localparam logic [6:0] OP_I   = 7'd19;
  localparam logic [6:0] OP_BEQ = 7'd99;
  localparam logic [6:0] OP_JAL = 7'd111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // One-hot instruction class; all zero means unsupported opcode.
  typedef struct packed {
    logic ld;
    logic st;
    logic rtype;
    logic itype;
    logic beq;
    logic jal;
  } op_class_t;

endpackage

// File: rtl/opClassDeco.sv
// Opcode -> one-hot instruction class decoder used by the DECODE and
// MEMADR next-state logic.
module opClassDeco
  import ctrl_pkg::*;
(
  input  logic [6:0] op,
  output op_class_t  cls
);

  // Pure decode; unknown opcodes leave every class bit low.
  always_comb begin
    cls = '0;
    case (op)
      OP_LW:   cls.ld    = 1'b1;
      OP_SW:   cls.st    = 1'b1;
      OP_R:    cls.rtype = 1'b1;
      OP_I:    cls.itype = 1'b1;
      OP_BEQ:  cls.beq   = 1'b1;
      OP_JAL:  cls.jal   = 1'b1;
      default: cls       = '0;
    endcase
  end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Moore control FSM for a multi-cycle RISC-V style datapath.
// ILLEGAL_TRAP_EN: when defined, unsupported opcodes park the FSM in TRAP
// (all strobes low, illegalOp high) until reset; otherwise they retire as a
// two-cycle NOP and illegalOp stays low.
module multi_cycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [6:0]         op,
  input  logic               memReady,
  output logic               pcUpdate,
  output logic               branch,
  output logic               adrSrc,
  output logic               irWrite,
  output logic               memWrite,
  output logic               regWrite,
  output logic [1:0]         resultSrc,
  output logic [1:0]         aluSrcA,
  output logic [1:0]         aluSrcB,
  output logic [1:0]         aluOp,
  output logic [STATE_W-1:0] state,
  output logic               illegalOp
);

  state_e    state_q, state_d;
  op_class_t cls;

  opClassDeco u_deco (
    .op  (op),
    .cls (cls)
  );

  // State register; async reset aborts any instruction in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Next-state: memory states stall on memReady, DECODE dispatches on class.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (memReady) state_d = S_DECODE;
      S_DECODE: begin
        if (cls.ld || cls.st) state_d = S_MEMADR;
        else if (cls.rtype)   state_d = S_EXECR;
        else if (cls.itype)   state_d = S_EXECI;
        else if (cls.beq)     state_d = S_BEQ;
        else if (cls.jal)     state_d = S_JAL;
`ifdef ILLEGAL_TRAP_EN
        else                  state_d = S_TRAP;
`else
        else                  state_d = S_FETCH;
`endif
      end
      S_MEMADR: begin
        if (cls.ld)      state_d = S_MEMREAD;
        else if (cls.st) state_d = S_MEMWRITE;
        else             state_d = S_FETCH;
      end
      S_MEMREAD:  if (memReady) state_d = S_MEMWB;
      S_MEMWRITE: if (memReady) state_d = S_FETCH;
      S_MEMWB, S_ALUWB, S_BEQ: state_d = S_FETCH;
      S_EXECR, S_EXECI, S_JAL: state_d = S_ALUWB;
`ifdef ILLEGAL_TRAP_EN
      S_TRAP:     state_d = S_TRAP;
`endif
      default:    state_d = S_FETCH;
    endcase
  end

  // Moore outputs; the FETCH write enables also follow memReady and are
  // forced low during reset so a stalled or reset fetch never bumps the PC.
  always_comb begin
    pcUpdate  = 1'b0;
    branch    = 1'b0;
    adrSrc    = 1'b0;
    irWrite   = 1'b0;
    memWrite  = 1'b0;
    regWrite  = 1'b0;
    resultSrc = RES_ALUOUT;
    aluSrcA   = SRCA_PC;
    aluSrcB   = SRCB_RS2;
    aluOp     = ALUOP_ADD;
    illegalOp = 1'b0;
    case (state_q)
      S_FETCH: begin
        aluSrcB   = SRCB_FOUR;
        resultSrc = RES_ALU;
        irWrite   = memReady & ~reset;
        pcUpdate  = memReady & ~reset;
      end
      S_DECODE: begin
        aluSrcA = SRCA_OLDPC;
        aluSrcB = SRCB_IMM;
      end
      S_MEMADR: begin
        aluSrcA = SRCA_RS1;
        aluSrcB = SRCB_IMM;
      end
      S_MEMREAD:  adrSrc = 1'b1;
      S_MEMWB: begin
        resultSrc = RES_MEM;
        regWrite  = 1'b1;
      end
      S_MEMWRITE: begin
        adrSrc   = 1'b1;
        memWrite = 1'b1;
      end
      S_EXECR: begin
        aluSrcA = SRCA_RS1;
        aluOp   = ALUOP_FUNCT;
      end
      S_EXECI: begin
        aluSrcA = SRCA_RS1;
        aluSrcB = SRCB_IMM;
        aluOp   = ALUOP_FUNCT;
      end
      S_ALUWB:    regWrite = 1'b1;
      S_BEQ: begin
        aluSrcA = SRCA_RS1;
        aluOp   = ALUOP_SUB;
        branch  = 1'b1;
      end
      S_JAL: begin
        aluSrcA  = SRCA_OLDPC;
        aluSrcB  = SRCB_FOUR;
        pcUpdate = 1'b1;
      end
`ifdef ILLEGAL_TRAP_EN
      S_TRAP:     illegalOp = 1'b1;
`endif
      default: ;
    endcase
  end

  assign state = STATE_W'(state_q);

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
module tb_multi_cycle_ctrl;
  import ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] op = 7'd0;
  logic       memReady = 1'b1;
  logic       pcUpdate, branch, adrSrc, irWrite, memWrite, regWrite, illegalOp;
  logic [1:0] resultSrc, aluSrcA, aluSrcB, aluOp;
  logic [3:0] state;

  multi_cycle_ctrl #(.STATE_W(4)) dut (
    .clk(clk), .reset(reset), .op(op), .memReady(memReady),
    .pcUpdate(pcUpdate), .branch(branch), .adrSrc(adrSrc), .irWrite(irWrite),
    .memWrite(memWrite), .regWrite(regWrite), .resultSrc(resultSrc),
    .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .aluOp(aluOp), .state(state),
    .illegalOp(illegalOp)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic       pcu, br, adr, irw, mw, rw;
    logic [1:0] rs, sa, sb, ao;
    logic       ill;
  } obs_t;

  typedef struct {
    obs_t  e;
    string tag;
  } sb_t;

  sb_t sb_q[$];
  int  n_chk = 0;
  int  n_fail = 0;
  int  n_mon = 0;

  function automatic obs_t exp_of(state_e st, logic mr, logic rst);
    obs_t e = '0;
    e.st = st;
    case (st)
      S_FETCH:    begin e.sb = 2'b10; e.rs = 2'b10; e.irw = mr & ~rst; e.pcu = mr & ~rst; end
      S_DECODE:   begin e.sa = 2'b01; e.sb = 2'b01; end
      S_MEMADR:   begin e.sa = 2'b10; e.sb = 2'b01; end
      S_MEMREAD:  begin e.adr = 1'b1; end
      S_MEMWB:    begin e.rs = 2'b01; e.rw = 1'b1; end
      S_MEMWRITE: begin e.adr = 1'b1; e.mw = 1'b1; end
      S_EXECR:    begin e.sa = 2'b10; e.ao = 2'b10; end
      S_EXECI:    begin e.sa = 2'b10; e.sb = 2'b01; e.ao = 2'b10; end
      S_ALUWB:    begin e.rw = 1'b1; end
      S_BEQ:      begin e.sa = 2'b10; e.ao = 2'b01; e.br = 1'b1; end
      S_JAL:      begin e.sa = 2'b01; e.sb = 2'b10; e.pcu = 1'b1; end
`ifdef ILLEGAL_TRAP_EN
      S_TRAP:     begin e.ill = 1'b1; end
`endif
      default: ;
    endcase
    return e;
  endfunction

  task automatic step(input logic [6:0] o, input logic mr, input logic rst,
                      input state_e st, input string tag);
    sb_t s;
    @(negedge clk);
    op = o; memReady = mr; reset = rst;
    s.e = exp_of(st, mr, rst);
    s.tag = tag;
    sb_q.push_back(s);
  endtask

  always @(negedge clk) begin
    sb_t  s;
    obs_t act;
    #2;
    if (sb_q.size() != 0) begin
      s = sb_q.pop_front();
      act = {state, pcUpdate, branch, adrSrc, irWrite, memWrite, regWrite,
             resultSrc, aluSrcA, aluSrcB, aluOp, illegalOp};
      n_chk++;
      n_mon++;
      if (act !== s.e) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h", s.tag, act, s.e);
      end
    end
  end

  initial begin
    step(7'd0, 1'b1, 1'b1, S_FETCH, "reset_hold");
    #1;
    n_chk++;
    if (state !== 4'(S_FETCH) || pcUpdate !== 1'b0 || irWrite !== 1'b0) begin
      n_fail++;
      $display("FAIL inline reset_hold: state=%0d pcu=%b irw=%b", state, pcUpdate, irWrite);
    end
    step(7'd0, 1'b1, 1'b1, S_FETCH, "reset_hold2");

    step(OP_LW, 1'b1, 1'b0, S_FETCH,   "lw_fetch");
    step(OP_LW, 1'b1, 1'b0, S_DECODE,  "lw_decode");
    step(OP_LW, 1'b1, 1'b0, S_MEMADR,  "lw_memadr");
    step(OP_LW, 1'b1, 1'b0, S_MEMREAD, "lw_memread");
    step(OP_LW, 1'b1, 1'b0, S_MEMWB,   "lw_memwb");
    #1;
    n_chk++;
    if (regWrite !== 1'b1 || resultSrc !== RES_MEM) begin
      n_fail++;
      $display("FAIL inline lw_memwb: rw=%b rs=%b", regWrite, resultSrc);
    end

    step(OP_SW, 1'b1, 1'b0, S_FETCH,    "sw_fetch");
    step(OP_SW, 1'b1, 1'b0, S_DECODE,   "sw_decode");
    step(OP_SW, 1'b1, 1'b0, S_MEMADR,   "sw_memadr");
    step(OP_SW, 1'b0, 1'b0, S_MEMWRITE, "sw_wr_wait1");
    step(OP_SW, 1'b0, 1'b0, S_MEMWRITE, "sw_wr_wait2");
    step(OP_SW, 1'b1, 1'b0, S_MEMWRITE, "sw_wr_done");

    step(OP_BEQ, 1'b0, 1'b0, S_FETCH,  "beq_fetch_stall");
    step(OP_BEQ, 1'b1, 1'b0, S_FETCH,  "beq_fetch");
    step(OP_BEQ, 1'b1, 1'b0, S_DECODE, "beq_decode");
    step(OP_BEQ, 1'b1, 1'b0, S_BEQ,    "beq_exec");
    #1;
    n_chk++;
    if (branch !== 1'b1 || aluOp !== ALUOP_SUB || regWrite !== 1'b0) begin
      n_fail++;
      $display("FAIL inline beq_exec: br=%b ao=%b rw=%b", branch, aluOp, regWrite);
    end

    step(OP_JAL, 1'b1, 1'b0, S_FETCH,  "jal_fetch");
    step(OP_JAL, 1'b1, 1'b0, S_DECODE, "jal_decode");
    step(OP_JAL, 1'b1, 1'b0, S_JAL,    "jal_exec");
    step(OP_JAL, 1'b1, 1'b0, S_ALUWB,  "jal_aluwb");

    step(OP_I, 1'b1, 1'b0, S_FETCH,  "i_fetch");
    step(OP_I, 1'b1, 1'b0, S_DECODE, "i_decode");
    step(OP_I, 1'b1, 1'b0, S_EXECI,  "i_exec");
    step(OP_I, 1'b1, 1'b0, S_ALUWB,  "i_aluwb");

    step(OP_LW, 1'b1, 1'b0, S_FETCH,   "lw2_fetch");
    step(OP_LW, 1'b1, 1'b0, S_DECODE,  "lw2_decode");
    step(OP_LW, 1'b1, 1'b0, S_MEMADR,  "lw2_memadr");
    step(OP_LW, 1'b0, 1'b0, S_MEMREAD, "lw2_rd_wait");
    step(OP_LW, 1'b1, 1'b0, S_MEMREAD, "lw2_rd_done");
    step(OP_LW, 1'b1, 1'b0, S_MEMWB,   "lw2_memwb");

    step(OP_R, 1'b1, 1'b0, S_FETCH,  "r_fetch");
    step(OP_R, 1'b1, 1'b0, S_DECODE, "r_decode");
    step(OP_R, 1'b1, 1'b0, S_EXECR,  "r_exec");
    step(OP_R, 1'b1, 1'b1, S_FETCH,  "r_async_reset");
    #1;
    n_chk++;
    if (state !== 4'(S_FETCH) || regWrite !== 1'b0) begin
      n_fail++;
      $display("FAIL inline r_async_reset: state=%0d rw=%b", state, regWrite);
    end
    step(OP_R, 1'b1, 1'b0, S_FETCH,  "r_after_reset");
    step(OP_R, 1'b1, 1'b0, S_DECODE, "r2_decode");
    step(OP_R, 1'b1, 1'b0, S_EXECR,  "r2_exec");
    step(OP_R, 1'b1, 1'b0, S_ALUWB,  "r2_aluwb");

    step(7'h7F, 1'b1, 1'b0, S_FETCH,  "ill_fetch");
    step(7'h7F, 1'b1, 1'b0, S_DECODE, "ill_decode");
`ifdef ILLEGAL_TRAP_EN
    step(7'h7F, 1'b1, 1'b0, S_TRAP,   "ill_trap1");
    #1;
    n_chk++;
    if (illegalOp !== 1'b1) begin
      n_fail++;
      $display("FAIL inline ill_trap1: ill=%b", illegalOp);
    end
    step(OP_R,  1'b1, 1'b0, S_TRAP,   "ill_trap2");
    step(OP_R,  1'b1, 1'b0, S_TRAP,   "ill_trap3");
    step(OP_R,  1'b1, 1'b1, S_FETCH,  "ill_reset");
    step(OP_R,  1'b1, 1'b0, S_FETCH,  "ill_recover");
`else
    step(7'h7F, 1'b1, 1'b0, S_FETCH,  "ill_nop_fetch");
    #1;
    n_chk++;
    if (illegalOp !== 1'b0 || state !== 4'(S_FETCH)) begin
      n_fail++;
      $display("FAIL inline ill_nop_fetch: ill=%b state=%0d", illegalOp, state);
    end
    step(7'h7F, 1'b1, 1'b0, S_DECODE, "ill_nop_decode2");
    step(7'h7F, 1'b1, 1'b0, S_FETCH,  "ill_nop_fetch2");
`endif

    @(negedge clk);
    #5;
    n_chk++;
    if (n_mon < 40) begin
      n_fail++;
      $display("FAIL monitor ran only %0d checks", n_mon);
    end
    if (n_fail != 0) $display("FAIL summary: %0d failures", n_fail);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not reach its end, checked %0d", n_chk);
    $fatal(1, "timeout");
  end

endmodule
